snn_stim_sequencer: RTL and testbench

Hardware replacement for the bench-driven stimulus/capture loop around `snn_core`. The block:
- fetches one event vector per timestep from an external event memory;
- presents it to the core and gates the core's advance with a one-cycle `core_en` strobe;
- captures the resulting spike row into an internal output FIFO with step index and last flag.

It adds three things the free-running bench loop lacks: single-step core gating, output backpressure, and looped replay with abort. It sits between the event RAM, `snn_core` and the host/readout stream.

---
 rtl/snn_stim_sequencer.sv | 165 ++++++++++++++++
 tb/tb_snn_stim_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_stim_sequencer.sv
// Purpose: fetches one event vector per timestep, single-steps snn_core, captures spike rows in a FWFT FIFO.
// Latency: 4 cycles per step unstalled (FETCH, LOAD, STEP, CAPTURE); a row is visible the cycle after its push.
// Backpressure: a full output FIFO holds the sequencer in CAPTURE with no push and no further core_en.
module snn_stim_sequencer #(
  parameter int F          = 48,
  parameter int N          = 96,
  parameter int STEP_W     = 16,
  parameter int EV_AW      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [EV_AW-1:0]  base_addr,
  input  logic              loop_en,
  output logic              busy,
  output logic              done,
  output logic              ev_rd_en,
  output logic [EV_AW-1:0]  ev_rd_addr,
  input  logic [F-1:0]      ev_rd_data,
  output logic [F-1:0]      core_event_vec,
  output logic              core_en,
  input  logic [N-1:0]      core_spikes,
  output logic              spk_valid,
  input  logic              spk_ready,
  output logic [N-1:0]      spk_data,
  output logic [STEP_W-1:0] spk_step,
  output logic              spk_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = N + STEP_W + 1;
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_STEP    = 3'd3,
    S_CAPTURE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   nsteps_q;
  logic [EV_AW-1:0]    base_q;
  logic                loop_q;
  logic [STEP_W-1:0]   step_q;
  logic [F-1:0]        ev_vec_q;
  logic                done_q;

  logic [RW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [PW:0]         cnt_q;

  logic                is_last;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                run_abort;
  logic [RW-1:0]       head;

  assign is_last   = (step_q == (nsteps_q - STEP_W'(1)));
  assign fifo_full = (cnt_q == CNT_FULL);
  assign run_abort = abort && (state_q != S_IDLE);
  // Abort wins over a capture in the same cycle; the row is dropped.
  assign push      = (state_q == S_CAPTURE) && !abort && !fifo_full;
  assign pop       = spk_valid && spk_ready;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: abort overrides every other transition outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && (num_steps != '0)) state_d = S_FETCH;
      S_FETCH:   state_d = S_LOAD;
      S_LOAD:    state_d = S_STEP;
      S_STEP:    state_d = S_CAPTURE;
      S_CAPTURE: if (push) state_d = (is_last && !loop_q) ? S_IDLE : S_FETCH;
      default:   state_d = S_IDLE;
    endcase
    if (run_abort) state_d = S_IDLE;
  end

  // Moore outputs decoded from the current state
  always_comb begin
    busy       = (state_q != S_IDLE);
    ev_rd_en   = (state_q == S_FETCH);
    ev_rd_addr = (state_q == S_FETCH) ? (base_q + EV_AW'(step_q)) : '0;
    core_en    = (state_q == S_STEP);
  end

  // Run parameters, step counter, event vector and completion pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nsteps_q <= '0;
      base_q   <= '0;
      loop_q   <= 1'b0;
      step_q   <= '0;
      ev_vec_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_IDLE && start && num_steps == '0) ||
                (push && is_last && !loop_q);
      if (state_q == S_IDLE && start) begin
        nsteps_q <= num_steps;
        base_q   <= base_addr;
        loop_q   <= loop_en;
        step_q   <= '0;
      end else if (push) begin
        step_q <= is_last ? '0 : (step_q + STEP_W'(1));
      end
      if (run_abort)                 ev_vec_q <= '0;
      else if (state_q == S_LOAD)    ev_vec_q <= ev_rd_data;
    end
  end

  assign done           = done_q;
  assign core_event_vec = ev_vec_q;

  // FIFO storage; contents are don't-care until written, outputs are masked when empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {core_spikes, step_q, is_last};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head-of-FIFO view, forced to zero when nothing is queued
  always_comb begin
    head      = mem_q[rptr_q];
    spk_valid = (cnt_q != '0);
    spk_data  = '0;
    spk_step  = '0;
    spk_last  = 1'b0;
    if (spk_valid) begin
      spk_data = head[RW-1 -: N];
      spk_step = head[STEP_W:1];
      spk_last = head[0];
    end
  end

endmodule

// File: tb/tb_snn_stim_sequencer.sv
module tb_snn_stim_sequencer;
  localparam int F = 48;
  localparam int N = 96;
  localparam int SW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, abort, loop_en, spk_ready;
  logic [SW-1:0] num_steps;
  logic [AW-1:0] base_addr;
  logic          busy, done, ev_rd_en, core_en, spk_valid, spk_last;
  logic [AW-1:0] ev_rd_addr;
  logic [F-1:0]  ev_rd_data;
  logic [F-1:0]  core_event_vec;
  logic [N-1:0]  core_spikes;
  logic [N-1:0]  spk_data;
  logic [SW-1:0] spk_step;

  snn_stim_sequencer #(.F(F), .N(N), .STEP_W(SW), .EV_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .num_steps(num_steps),
    .base_addr(base_addr), .loop_en(loop_en), .busy(busy), .done(done),
    .ev_rd_en(ev_rd_en), .ev_rd_addr(ev_rd_addr), .ev_rd_data(ev_rd_data),
    .core_event_vec(core_event_vec), .core_en(core_en), .core_spikes(core_spikes),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_data(spk_data),
    .spk_step(spk_step), .spk_last(spk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  d;
    logic [SW-1:0] s;
    logic          l;
  } row_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   rows_seen = 0;
  row_t exp_q[$];
  logic [AW-1:0] addr_q[$];
  int   core_cyc_q[$];

  function automatic logic [F-1:0] evpat(input logic [AW-1:0] a);
    return {a, a ^ 16'h5A5A, ~a};
  endfunction

  function automatic logic [N-1:0] spkpat(input logic [F-1:0] ev);
    return {ev ^ 48'h0F0F_F0F0_3C3C, ev};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic l);
    row_t r;
    r.d = spkpat(evpat(a));
    r.s = s;
    r.l = l;
    exp_q.push_back(r);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt - prev, 1);
  endtask

  task automatic check_addr(input int idx, input logic [AW-1:0] e);
    if (idx < addr_q.size()) check("ev_rd_addr", addr_q[idx], e);
    else check("ev_rd_addr_missing", addr_q.size(), idx + 1);
  endtask

  task automatic clear_logs();
    addr_q.delete();
    core_cyc_q.delete();
    rows_seen = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ev_rd_en"}, ev_rd_en, 0);
    check({tag, "_ev_rd_addr"}, ev_rd_addr, 0);
    check({tag, "_core_event_vec"}, core_event_vec, 0);
    check({tag, "_core_en"}, core_en, 0);
    check({tag, "_spk_valid"}, spk_valid, 0);
    check({tag, "_spk_data"}, spk_data, 0);
    check({tag, "_spk_step"}, spk_step, 0);
    check({tag, "_spk_last"}, spk_last, 0);
  endtask

  // Event memory: read data valid one cycle after the strobe
  always @(posedge clk) if (ev_rd_en) ev_rd_data <= evpat(ev_rd_addr);

  // Core stand-in: spike row registered on the core_en edge
  always @(posedge clk or negedge rstn) begin
    if (!rstn) core_spikes <= '0;
    else if (core_en) core_spikes <= spkpat(core_event_vec);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and scoreboard pop, sampled mid-cycle
  always @(negedge clk) begin
    row_t e;
    if (core_en) core_cyc_q.push_back(cyc + 1);
    if (ev_rd_en) addr_q.push_back(ev_rd_addr);
    if (done) begin
      done_cnt++;
      done_cyc = cyc + 1;
    end
    if (spk_valid && spk_ready) begin
      if (exp_q.size() == 0) begin
        check("row_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("row_data", spk_data, e.d);
        check("row_step", spk_step, e.s);
        check("row_last", spk_last, e.l);
        rows_seen++;
      end
    end
  end

  initial begin
    int e_cyc;
    int d0;
    int c0;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0; spk_ready = 1'b0;
    num_steps = '0; base_addr = '0;
    tick(3);
    check_all_zero("reset");
    rstn = 1'b1;
    tick(2);

    // Basic run: 3 steps from address 0
    clear_logs();
    spk_ready = 1'b1;
    for (int s = 0; s < 3; s++) push_exp(AW'(s), SW'(s), s == 2);
    num_steps = 3; base_addr = 16'h0000; loop_en = 1'b0;
    d0 = done_cnt;
    start = 1'b1; e_cyc = cyc + 1;
    tick();
    start = 1'b0;
    check("basic_busy", busy, 1);
    wait_done(d0, 60);
    tick(3);
    check("basic_done_cycle", done_cyc, e_cyc + 13);
    check("basic_done_count", done_cnt - d0, 1);
    check("basic_addr_count", addr_q.size(), 3);
    for (int i = 0; i < 3; i++) check_addr(i, AW'(i));
    check("basic_core_en_count", core_cyc_q.size(), 3);
    for (int i = 0; i < 3 && i < core_cyc_q.size(); i++)
      check("basic_core_en_cycle", core_cyc_q[i], e_cyc + 3 + 4 * i);
    check("basic_rows", rows_seen, 3);
    check("basic_busy_end", busy, 0);

    // Backpressure: 6 steps into a 4-deep FIFO with the consumer stalled
    clear_logs();
    spk_ready = 1'b0;
    for (int s = 0; s < 6; s++) push_exp(16'h0100 + AW'(s), SW'(s), s == 5);
    num_steps = 6; base_addr = 16'h0100;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(40);
    check("bp_core_en_count", core_cyc_q.size(), 5);
    check("bp_busy_hold", busy, 1);
    check("bp_core_en_low", core_en, 0);
    check("bp_done_none", done_cnt - d0, 0);
    check("bp_head_valid", spk_valid, 1);
    check("bp_head_step", spk_step, 0);
    check("bp_head_data", spk_data, spkpat(evpat(16'h0100)));
    spk_ready = 1'b1;
    wait_done(d0, 80);
    tick(4);
    check("bp_core_en_total", core_cyc_q.size(), 6);
    check("bp_rows", rows_seen, 6);
    check("bp_queue_empty", exp_q.size(), 0);

    // Zero steps: immediate done, no activity
    clear_logs();
    num_steps = 0; base_addr = 16'h0033;
    d0 = done_cnt;
    start = 1'b1; e_cyc = cyc + 1;
    tick();
    start = 1'b0;
    tick(5);
    check("zero_done_count", done_cnt - d0, 1);
    check("zero_done_cycle", done_cyc, e_cyc + 1);
    check("zero_no_reads", addr_q.size(), 0);
    check("zero_no_core_en", core_cyc_q.size(), 0);
    check("zero_fifo_empty", spk_valid, 0);

    // Looped pass across the address wrap, aborted in STEP of global step 3
    clear_logs();
    spk_ready = 1'b0;
    push_exp(16'hFFFF, 0, 1'b0);
    push_exp(16'h0000, 1, 1'b1);
    push_exp(16'hFFFF, 0, 1'b0);
    num_steps = 2; base_addr = 16'hFFFF; loop_en = 1'b1;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0; loop_en = 1'b0;
    tick(14);
    check("loop_in_step", core_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_vec_cleared", core_event_vec, 0);
    tick(6);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_fifo_retained", spk_valid, 1);
    check("loop_addr_count", addr_q.size(), 4);
    check_addr(0, 16'hFFFF);
    check_addr(1, 16'h0000);
    check_addr(2, 16'hFFFF);
    check_addr(3, 16'h0000);
    check("loop_core_en_count", core_cyc_q.size(), 4);
    spk_ready = 1'b1;
    tick(6);
    check("loop_rows_drained", rows_seen, 3);
    check("loop_queue_empty", exp_q.size(), 0);
    check("loop_fifo_empty", spk_valid, 0);

    // Start while busy is ignored; reset mid-STEP clears everything
    clear_logs();
    spk_ready = 1'b0;
    num_steps = 4; base_addr = 16'h0020;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    num_steps = 1; base_addr = 16'h0099; start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    check("busy_in_step", core_en, 1);
    check("busy_head_step", spk_step, 0);
    check("busy_fifo_rows", spk_valid, 1);
    check("busy_addr_count", addr_q.size(), 3);
    for (int i = 0; i < 3; i++) check_addr(i, 16'h0020 + AW'(i));
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rstn = 1'b1;
    tick();

    // Fresh run after reset replays from step 0
    clear_logs();
    spk_ready = 1'b1;
    push_exp(16'h0040, 0, 1'b0);
    push_exp(16'h0041, 1, 1'b1);
    num_steps = 2; base_addr = 16'h0040;
    d0 = done_cnt;
    c0 = n_cmp;
    start = 1'b1; e_cyc = cyc + 1;
    tick();
    start = 1'b0;
    wait_done(d0, 40);
    tick(3);
    check("rerun_done_cycle", done_cyc, e_cyc + 9);
    check("rerun_addr_count", addr_q.size(), 2);
    check_addr(0, 16'h0040);
    check_addr(1, 16'h0041);
    check("rerun_rows", rows_seen, 2);
    check("rerun_row_checks", n_cmp - c0 > 6, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
